// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with one registered, id-tagged response slot. Optional macro: ALU_ARB_SEL_CHECK_EN.
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int SELW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SELW-1:0] req0_sel,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SELW-1:0] req1_sel,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [SELW-1:0] alu_sel_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_data
`ifdef ALU_ARB_SEL_CHECK_EN
  ,
  output logic            rsp_err
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_r;
  state_t          state_nx;
  logic            last_grant_r;
  logic            can_issue;
  logic            grant0;
  logic            grant1;
  logic            granted;
  logic            sel_bad;
  logic [SELW-1:0] pick_sel;
  logic [XLEN-1:0] pick_a;
  logic [XLEN-1:0] pick_b;

`ifdef ALU_ARB_SEL_CHECK_EN
  function automatic logic sel_legal(input logic [SELW-1:0] sel);
    return (sel <= SELW'(4'd9)) || (sel == SELW'(4'd11));
  endfunction
`endif

  // Round-robin grant; the requester that did not win last time wins a conflict
  always_comb begin
    can_issue = (state_r == IDLE) || rsp_ready;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (!can_issue) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end else if (req0_valid && req1_valid) begin
      grant0 = last_grant_r;
      grant1 = !last_grant_r;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
    granted    = grant0 || grant1;
    req0_ready = grant0;
    req1_ready = grant1;
  end

  // Steer the granted requester onto the ALU; idle or rejected ops drive zeros
  always_comb begin
    pick_sel = req0_sel;
    pick_a   = req0_a;
    pick_b   = req0_b;
    if (grant1) begin
      pick_sel = req1_sel;
      pick_a   = req1_a;
      pick_b   = req1_b;
    end else begin
      pick_sel = req0_sel;
      pick_a   = req0_a;
      pick_b   = req0_b;
    end
`ifdef ALU_ARB_SEL_CHECK_EN
    sel_bad = granted && !sel_legal(pick_sel);
`else
    sel_bad = 1'b0;
`endif
    if (granted && !sel_bad) begin
      alu_sel_o = pick_sel;
      alu_a_o   = pick_a;
      alu_b_o   = pick_b;
    end else begin
      alu_sel_o = {SELW{1'b0}};
      alu_a_o   = {XLEN{1'b0}};
      alu_b_o   = {XLEN{1'b0}};
    end
  end

  // Slot occupancy: a grant always (re)fills it, a drain without grant empties it
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (granted) state_nx = HOLD;
        else         state_nx = IDLE;
      end
      HOLD: begin
        if (granted)         state_nx = HOLD;
        else if (rsp_ready)  state_nx = IDLE;
        else                 state_nx = HOLD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, priority pointer and response slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      rsp_id       <= 1'b0;
      rsp_data     <= {XLEN{1'b0}};
`ifdef ALU_ARB_SEL_CHECK_EN
      rsp_err      <= 1'b0;
`endif
    end else begin
      state_r <= state_nx;
      if (granted) begin
        last_grant_r <= grant1;
        rsp_id       <= grant1;
        rsp_data     <= sel_bad ? {XLEN{1'b0}} : alu_result_i;
`ifdef ALU_ARB_SEL_CHECK_EN
        rsp_err      <= sel_bad;
`endif
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  assign rsp_valid = (state_r == HOLD);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, for example the main execute path and an auxiliary address/compare unit.
- Arbitrates round-robin, drives the ALU select and operands for the granted requester, and registers the ALU result into one shared response slot.
- The response slot is tagged with the requester id and has valid/ready backpressure.
- Throughput is one operation per cycle when responses are drained every cycle.

Parameters:
XLEN, 32, operand/result width
SELW, 4, ALU select width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 granted this cycle (handshake completes when valid&&ready)
req0_sel  in  SELW  ALU op code for requester 0
req0_a  in  XLEN  operand A for requester 0
req0_b  in  XLEN  operand B for requester 0
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 granted this cycle
req1_sel  in  SELW  ALU op code for requester 1
req1_a  in  XLEN  operand A for requester 1
req1_b  in  XLEN  operand B for requester 1
alu_sel_o  out  SELW  to ALU select
alu_a_o  out  XLEN  to ALU operand A
alu_b_o  out  XLEN  to ALU operand B
alu_result_i  in  XLEN  from ALU result
rsp_valid  out  1  response slot holds a result
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the held result
rsp_data  out  XLEN  registered ALU result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - FSM=IDLE.
  - last_grant=1, so requester 0 has first priority.
- FSM states:
  - IDLE: slot empty.
  - HOLD: slot full, rsp_valid=1.
- can_issue = (state==IDLE) || rsp_ready. This is combinational.
- Grant, combinational:
  - Granted only when can_issue is true.
  - If exactly one requester is valid, that requester is granted.
  - If both are valid, the requester != last_grant is granted.
  - reqN_ready = grantN. At most one ready is high per cycle.
  - ready never depends on the requester's own ready. It may depend on valid.
- ALU drive:
  - With a grant, alu_sel_o/alu_a_o/alu_b_o equal the granted requester's fields.
  - With no grant, all three are driven 0.
- Capture, on a granted cycle:
  - rsp_data <= alu_result_i; rsp_id <= granted id; last_grant <= granted id.
  - Next state is HOLD.
  - Latency: result visible one cycle after the handshake.
- Transitions:
  - IDLE, no grant: stay IDLE.
  - HOLD, rsp_ready=1, no grant: go to IDLE, rsp_valid drops next cycle.
  - HOLD, rsp_ready=1 with grant: drain and reload in the same cycle, stay HOLD with new data.
  - HOLD, rsp_ready=0: stay HOLD. rsp_data/rsp_id are held stable, all reqN_ready=0.
- last_grant changes only on a grant. Idle cycles do not rotate priority.
- Requester rule: a requester may drop valid or change fields while not granted. The arbiter holds no per-requester state beyond last_grant.
- Reset mid-operation: a held result is discarded, rsp_valid=0 on the next cycle, and priority returns to requester 0.
- Arithmetic: the block passes operands unmodified. No width extension, no result alteration.

Optional Feature:
- Macro: ALU_ARB_SEL_CHECK_EN.
- When defined:
  - Adds output rsp_err (1 bit, reset 0), captured alongside rsp_data.
  - A granted op whose sel is not one of 0x0-0x9 or 0xB (i.e. 0xA, 0xC-0xF) is still handshaken.
  - For such an op, alu_sel_o/alu_a_o/alu_b_o are driven 0 and rsp_data is captured as 0 with rsp_err=1.
  - Legal ops capture rsp_err=0.
- When undefined:
  - The rsp_err port is absent.
  - All sel codes are forwarded unchanged and alu_result_i is captured as-is.

Test Plan:
- Reset, then req0 only: sel=0x0, a=5, b=7 -> req0_ready=1 that cycle, alu_a_o=5. Next cycle rsp_valid=1, rsp_id=0, rsp_data=12.
- Both valid every cycle, rsp_ready=1 tied high -> grants alternate 0,1,0,1. req1 op sel=0x7, a=0x80000000, b=4 returns rsp_data=0xF8000000 with rsp_id=1.
- Backpressure: rsp_ready=0 for 3 cycles while HOLD with req1 valid -> rsp_data stable and req1_ready=0 for those cycles. On rsp_ready=1, req1 is granted and the new result appears the next cycle.
- Single requester streaming (req1 sel=0x1, a=10, b=3, rsp_ready=1 tied high) -> a handshake every cycle, rsp_data=7 each cycle. Priority after stream: req0 wins the next conflict.
- Reset asserted while HOLD with rsp_valid=1 -> rsp_valid=0 the next cycle. A subsequent conflict grants req0 first.
- With ALU_ARB_SEL_CHECK_EN: req0 sel=0xC -> handshake completes, alu_sel_o=0, rsp_data=0, rsp_err=1. A following sel=0x9, a=0xF0, b=0x3C gives rsp_data=0x30, rsp_err=0.
